video_timing_ctrl: RTL and testbench
====================================

Name: video_timing_ctrl

Overview:
Sequences the HDMI colour-bar / test-pattern datapath.
- Generates the 1280x720@60 raster counters, sync/DE strobes and the one-cycle-early pixel request with x/y coordinates that the pattern generator registers into pixel data.
- Owns the pattern-select register and changes it only at frame boundaries, through a req/ack handshake with the control logic (keys / UART), so no frame shows a torn pattern.

Parameters:
H_SYNC, 40, hsync width in pixel clocks
H_BACK, 220, horizontal back porch
H_DISP, 1280, active pixels per line
H_FRONT, 110, horizontal front porch
H_TOTAL, 1650, line length (= sum of the four above)
V_SYNC, 5, vsync width in lines
V_BACK, 20, vertical back porch
V_DISP, 720, active lines
V_FRONT, 5, vertical front porch
V_TOTAL, 750, frame length in lines

Ports:
pixel_clk  in  1  pixel clock; the only clock
sys_rst_n  in  1  asynchronous active-low reset
timing_en  in  1  1 = raster runs; 0 = counters held at 0
mode_req  in  1  level request to change pattern; held until mode_ack
mode_next  in  2  requested pattern; stable while mode_req=1
mode_ack  out  1  one-cycle pulse: request applied
pattern_sel  out  2  current pattern, to pattern generator
video_hs  out  1  hsync, active high
video_vs  out  1  vsync, active high
video_de  out  1  active-video strobe
data_req  out  1  pixel request, leads video_de by exactly 1 cycle
pixel_xpos  out  11  x coordinate of the requested pixel
pixel_ypos  out  11  y coordinate of the requested pixel
frame_start  out  1  one-cycle pulse at cnt_h=0, cnt_v=0
frame_cnt  out  8  completed-frame counter

Behaviour:
- Clock and reset: one clock, pixel_clk. Reset sys_rst_n is asynchronous, active-low.
- State: cnt_h (11b, 0..H_TOTAL-1) and cnt_v (11b, 0..V_TOTAL-1), pattern_sel, mode_ack, frame_cnt. All are registers cleared by reset.
- Counter advance (timing_en=1):
  - cnt_h increments every clock.
  - At H_TOTAL-1, cnt_h wraps to 0 and cnt_v increments.
  - At cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1, both wrap to 0.
- timing_en=0: cnt_h and cnt_v are synchronously forced to 0 and held. On re-enable, the raster restarts from (0,0), and frame_start pulses on the first enabled cycle at (0,0).
- Decoded outputs are combinational from the registered counters, so they are glitch-free relative to pixel_clk:
  - video_hs = cnt_h < H_SYNC
  - video_vs = cnt_v < V_SYNC
  - HA = H_SYNC+H_BACK (260); VA = V_SYNC+V_BACK (25)
  - video_de = (HA <= cnt_h < HA+H_DISP) and (VA <= cnt_v < VA+V_DISP)
  - data_req = same condition but horizontally one earlier: HA-1 <= cnt_h < HA+H_DISP-1
  - pixel_xpos = cnt_h-(HA-1) when data_req, else 0
  - pixel_ypos = cnt_v-VA when data_req, else 0
  - frame_start = timing_en and cnt_h=0 and cnt_v=0
- Latency contract: the pattern generator registers pixel data 1 cycle after data_req, which is exactly aligned with video_de. The x range is 0..1279 and the y range is 0..719.
- Reset values (counters at 0): video_hs=1, video_vs=1, video_de=0, data_req=0, pixel_xpos=0, pixel_ypos=0, frame_start=0 while in reset and 1 on the first enabled cycle, mode_ack=0, pattern_sel=0, frame_cnt=0.
- frame_cnt increments on the frame-end wrap cycle (cnt_h=H_TOTAL-1, cnt_v=V_TOTAL-1, timing_en=1). It wraps 255 -> 0.
- Mode handshake:
  - Apply point: the frame-end wrap cycle with mode_req=1. On that clock edge pattern_sel <= mode_next and mode_ack <= 1 (registered). mode_ack is therefore high for exactly the first cycle of the new frame, coincident with frame_start.
  - Otherwise mode_ack <= 0, and pattern_sel holds.
  - At most one apply per frame. If mode_req is still high at the next frame end, that is treated as a new request and applied again.
  - The requester drops mode_req on seeing mode_ack.
  - mode_req=1 while timing_en=0: nothing is applied until the raster runs and reaches frame end.
  - mode_next equal to the current pattern_sel is still acked.
- Reset asserted mid-frame: all state clears immediately (asynchronously). After release, the raster restarts at (0,0) and a pending request is lost; the requester re-requests.

Test Plan:
1. Release reset with timing_en=1 -> frame_start at cycle 0; video_hs high for 40 cycles/line; video_vs high for lines 0..4; video_de count per frame = 921600; frame period = 1237500 clocks.
2. Check the line at cnt_v=25 -> data_req rises at cnt_h=259 with pixel_xpos=0, pixel_ypos=0; video_de rises at 260; pixel_xpos=1279 at cnt_h=1538; data_req=0 at 1539; pixel_ypos=719 on line 744, then 0 for the rest of the frame.
3. Pulse mode_req=1, mode_next=2 at mid-frame -> pattern_sel stays 0 until the frame wrap; on the first cycle of the next frame, pattern_sel=2 and mode_ack=1 for 1 cycle coincident with frame_start.
4. Hold mode_req=1 for two full frames with mode_next=3 -> exactly two mode_ack pulses, one per frame boundary; pattern_sel=3.
5. Drop timing_en for 1000 cycles mid-frame, then raise it -> counters read 0 throughout; on re-enable frame_start=1, video_hs=1, video_vs=1; a mode_req raised while disabled is applied only at the next frame end.
6. Assert sys_rst_n=0 asynchronously mid-line (between clock edges), run 256 frames after release -> all outputs take reset values immediately; frame_cnt wraps 255 -> 0 at the 256th frame end.

Source files
------------

// File: rtl/video_timing_ctrl_if.sv
// rtl/video_timing_ctrl_if.sv - pattern-select handshake and raster outputs of the video timing controller
interface video_timing_ctrl_if;
    logic        mode_req;
    logic [1:0]  mode_next;
    logic        mode_ack;
    logic [1:0]  pattern_sel;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic        data_req;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        output mode_req, mode_next,
        input  mode_ack, pattern_sel, video_hs, video_vs, video_de,
        input  data_req, pixel_xpos, pixel_ypos, frame_start, frame_cnt
    );

    modport slave (
        input  mode_req, mode_next,
        output mode_ack, pattern_sel, video_hs, video_vs, video_de,
        output data_req, pixel_xpos, pixel_ypos, frame_start, frame_cnt
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - raster counters, sync/DE decode, early pixel request and frame-aligned pattern select
module video_timing_ctrl #(
    parameter int H_SYNC  = 40,
    parameter int H_BACK  = 220,
    parameter int H_DISP  = 1280,
    parameter int H_FRONT = 110,
    parameter int V_SYNC  = 5,
    parameter int V_BACK  = 20,
    parameter int V_DISP  = 720,
    parameter int V_FRONT = 5
) (
    input  logic                pixel_clk,
    input  logic                sys_rst_n,
    input  logic                timing_en,
    video_timing_ctrl_if.slave  vif
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_END    = 11'(H_SYNC);
    localparam logic [10:0] VS_END    = 11'(V_SYNC);
    localparam logic [10:0] DE_H_BEG  = 11'(HA);
    localparam logic [10:0] DE_H_END  = 11'(HA + H_DISP);
    localparam logic [10:0] REQ_H_BEG = 11'(HA - 1);
    localparam logic [10:0] REQ_H_END = 11'(HA + H_DISP - 1);
    localparam logic [10:0] ACT_V_BEG = 11'(VA);
    localparam logic [10:0] ACT_V_END = 11'(VA + V_DISP);

    logic [10:0] cnt_h_q, cnt_h_d;
    logic [10:0] cnt_v_q, cnt_v_d;
    logic [1:0]  pattern_sel_q, pattern_sel_d;
    logic        mode_ack_q, mode_ack_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic line_end;
    logic frame_end;
    logic v_active;
    logic h_req;
    logic h_de;

    assign line_end  = (cnt_h_q == H_LAST);
    assign frame_end = line_end && (cnt_v_q == V_LAST);

    always_comb begin
        cnt_h_d       = cnt_h_q;
        cnt_v_d       = cnt_v_q;
        frame_cnt_d   = frame_cnt_q;
        pattern_sel_d = pattern_sel_q;
        mode_ack_d    = 1'b0;

        if (!timing_en) begin
            cnt_h_d = '0;
            cnt_v_d = '0;
        end else if (line_end) begin
            cnt_h_d = '0;
            cnt_v_d = frame_end ? 11'd0 : cnt_v_q + 11'd1;
        end else begin
            cnt_h_d = cnt_h_q + 11'd1;
        end

        // Pattern changes only on the wrap into a new frame, so no frame is torn.
        if (timing_en && frame_end) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (vif.mode_req) begin
                pattern_sel_d = vif.mode_next;
                mode_ack_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q       <= '0;
            cnt_v_q       <= '0;
            frame_cnt_q   <= '0;
            pattern_sel_q <= '0;
            mode_ack_q    <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            frame_cnt_q   <= frame_cnt_d;
            pattern_sel_q <= pattern_sel_d;
            mode_ack_q    <= mode_ack_d;
        end
    end

    // data_req runs one pixel ahead of video_de so the generator's register lines up with DE.
    assign v_active = (cnt_v_q >= ACT_V_BEG) && (cnt_v_q < ACT_V_END);
    assign h_de     = (cnt_h_q >= DE_H_BEG)  && (cnt_h_q < DE_H_END);
    assign h_req    = (cnt_h_q >= REQ_H_BEG) && (cnt_h_q < REQ_H_END);

    assign vif.video_hs    = (cnt_h_q < HS_END);
    assign vif.video_vs    = (cnt_v_q < VS_END);
    assign vif.video_de    = h_de && v_active;
    assign vif.data_req    = h_req && v_active;
    assign vif.pixel_xpos  = vif.data_req ? (cnt_h_q - REQ_H_BEG) : 11'd0;
    assign vif.pixel_ypos  = vif.data_req ? (cnt_v_q - ACT_V_BEG) : 11'd0;
    assign vif.frame_start = sys_rst_n && timing_en && (cnt_h_q == 11'd0) && (cnt_v_q == 11'd0);
    assign vif.mode_ack    = mode_ack_q;
    assign vif.pattern_sel = pattern_sel_q;
    assign vif.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - directed self-checking bench for video_timing_ctrl on a reduced raster
module tb_video_timing_ctrl;

    // Reduced raster: H 2/3/8/2 -> 15 clocks, V 1/2/4/2 -> 9 lines, HA=5, VA=3, 135 clocks/frame.
    localparam int HT = 15;
    localparam int FR = 135;

    logic pixel_clk = 1'b0;
    logic sys_rst_n;
    logic timing_en;

    int tests_run    = 0;
    int tests_failed = 0;

    video_timing_ctrl_if vif();

    video_timing_ctrl #(
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(2)
    ) dut (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .timing_en (timing_en),
        .vif       (vif)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    int hs_n, vs_n, de_n, req_n, fs_n, ack_n, ack_fs_n, bad_n;
    int h, v;

    initial begin
        sys_rst_n     = 1'b0;
        timing_en     = 1'b1;
        vif.mode_req  = 1'b0;
        vif.mode_next = 2'd0;
        repeat (3) tick();

        check("rst_hs", vif.video_hs, 1);
        check("rst_vs", vif.video_vs, 1);
        check("rst_de", vif.video_de, 0);
        check("rst_req", vif.data_req, 0);
        check("rst_xy", {vif.pixel_xpos, vif.pixel_ypos}, 0);
        check("rst_fs", vif.frame_start, 0);
        check("rst_ack", vif.mode_ack, 0);
        check("rst_sel", vif.pattern_sel, 0);
        check("rst_fcnt", vif.frame_cnt, 0);

        sys_rst_n = 1'b1;
        #1;
        check("first_fs", vif.frame_start, 1);

        // One full frame: strobe totals and the active-edge details of lines 3, 6, 7.
        hs_n = 0; vs_n = 0; de_n = 0; req_n = 0; fs_n = 0;
        for (int i = 0; i < FR; i++) begin
            h = i % HT;
            v = i / HT;
            hs_n  += int'(vif.video_hs);
            vs_n  += int'(vif.video_vs);
            de_n  += int'(vif.video_de);
            req_n += int'(vif.data_req);
            fs_n  += int'(vif.frame_start);
            if (v == 3 && h == 3) check("req_before", vif.data_req, 0);
            if (v == 3 && h == 4) begin
                check("req_rise", vif.data_req, 1);
                check("x_first", vif.pixel_xpos, 0);
                check("y_first", vif.pixel_ypos, 0);
                check("de_lag", vif.video_de, 0);
            end
            if (v == 3 && h == 5) begin
                check("de_rise", vif.video_de, 1);
                check("x_second", vif.pixel_xpos, 1);
            end
            if (v == 3 && h == 11) begin
                check("x_last", vif.pixel_xpos, 7);
                check("req_last", vif.data_req, 1);
            end
            if (v == 3 && h == 12) begin
                check("req_fall", vif.data_req, 0);
                check("de_last", vif.video_de, 1);
                check("x_idle", vif.pixel_xpos, 0);
            end
            if (v == 3 && h == 13) check("de_fall", vif.video_de, 0);
            if (v == 6 && h == 4) check("y_last", vif.pixel_ypos, 3);
            if (v == 7 && h == 4) begin
                check("req_vblank", vif.data_req, 0);
                check("y_vblank", vif.pixel_ypos, 0);
            end
            tick();
        end
        check("hs_total", hs_n, 18);
        check("vs_total", vs_n, 15);
        check("de_total", de_n, 32);
        check("req_total", req_n, 32);
        check("fs_total", fs_n, 1);
        check("fs_period", vif.frame_start, 1);
        check("fcnt_1", vif.frame_cnt, 1);

        // Mid-frame request waits for the frame wrap.
        repeat (50) tick();
        vif.mode_req  = 1'b1;
        vif.mode_next = 2'd2;
        repeat (84) tick();
        check("sel_hold", vif.pattern_sel, 0);
        check("ack_hold", vif.mode_ack, 0);
        tick();
        check("sel_apply", vif.pattern_sel, 2);
        check("ack_pulse", vif.mode_ack, 1);
        check("ack_fs", vif.frame_start, 1);
        check("fcnt_2", vif.frame_cnt, 2);
        vif.mode_req = 1'b0;
        tick();
        check("ack_drop", vif.mode_ack, 0);
        check("sel_keep", vif.pattern_sel, 2);

        // Request held across two frame ends is applied once per frame.
        vif.mode_req  = 1'b1;
        vif.mode_next = 2'd3;
        ack_n = 0; ack_fs_n = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            ack_n    += int'(vif.mode_ack);
            ack_fs_n += int'(vif.mode_ack && vif.frame_start);
        end
        vif.mode_req = 1'b0;
        check("ack_count", ack_n, 2);
        check("ack_align", ack_fs_n, 2);
        check("sel_3", vif.pattern_sel, 3);
        check("fcnt_4", vif.frame_cnt, 4);

        // Disable mid-frame; a request raised while disabled must wait for a full frame.
        repeat (40) tick();
        timing_en = 1'b0;
        tick();
        bad_n = 0;
        for (int j = 0; j < 1000; j++) begin
            if (j == 500) begin
                vif.mode_req  = 1'b1;
                vif.mode_next = 2'd1;
            end
            if (!(vif.video_hs && vif.video_vs && !vif.video_de && !vif.data_req &&
                  !vif.frame_start && !vif.mode_ack && vif.pattern_sel == 2'd3))
                bad_n++;
            tick();
        end
        check("dis_bad", bad_n, 0);
        check("dis_fcnt", vif.frame_cnt, 4);
        timing_en = 1'b1;
        #1;
        check("en_fs", vif.frame_start, 1);
        check("en_hs_vs", {vif.video_hs, vif.video_vs}, 2'b11);
        repeat (134) tick();
        check("en_sel_hold", vif.pattern_sel, 3);
        check("en_ack_hold", vif.mode_ack, 0);
        tick();
        check("en_ack", vif.mode_ack, 1);
        check("en_sel", vif.pattern_sel, 1);
        check("fcnt_5", vif.frame_cnt, 5);
        vif.mode_req = 1'b0;

        // Asynchronous reset mid-line during active video, then 256 frames to wrap frame_cnt.
        repeat (51) tick();
        check("pre_rst_de", vif.video_de, 1);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("arst_de", vif.video_de, 0);
        check("arst_req", vif.data_req, 0);
        check("arst_hs_vs", {vif.video_hs, vif.video_vs}, 2'b11);
        check("arst_xy", {vif.pixel_xpos, vif.pixel_ypos}, 0);
        check("arst_fs", vif.frame_start, 0);
        check("arst_sel", vif.pattern_sel, 0);
        check("arst_fcnt", vif.frame_cnt, 0);
        tick();
        sys_rst_n = 1'b1;
        #1;
        check("rel_fs", vif.frame_start, 1);
        repeat (255 * FR) tick();
        check("fcnt_255", vif.frame_cnt, 255);
        repeat (FR) tick();
        check("fcnt_wrap", vif.frame_cnt, 0);
        check("wrap_fs", vif.frame_start, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
